// File: rtl/quad_fifo4.sv
// quad_fifo4: four-entry, 4-bit circular FIFO that feeds a quad 4:1 mux.
// The entry registers drive mux inputs InA..InD and rd_ptr drives mux
// select S, so the mux output is always the head-of-queue word.
// Optional sticky misuse flag 'err' is built only when the macro
// QUAD_FIFO4_ERR_EN is defined; otherwise err is tied low.
module quad_fifo4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       rd_en,
  output logic [3:0] ent0,
  output logic [3:0] ent1,
  output logic [3:0] ent2,
  output logic [3:0] ent3,
  output logic [1:0] rd_ptr,
  output logic [2:0] count,
  output logic       empty,
  output logic       full,
  output logic       err
);

  logic [3:0] r_ent [4];
  logic [1:0] r_wrPtr;
  logic [1:0] r_rdPtr;
  logic [2:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pushOk;
  logic w_popOk;

  // Occupancy flags come straight from the registered count, so they only
  // move on clock edges and there is no pointer-equality ambiguity.
  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == 3'd4);

  // A push is accepted when there is room, or when a simultaneous pop frees
  // the slot that the write pointer is sitting on. A pop needs data.
  assign w_pushOk = wr_en && (!w_full || rd_en);
  assign w_popOk  = rd_en && !w_empty;

  // Entry storage: write the pushed word at the write pointer; popped
  // entries are left as they are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_ent[i] <= 4'h0;
      end
    end else if (w_pushOk) begin
      r_ent[r_wrPtr] <= wr_data;
    end
  end

  // Write and read pointers wrap 3 -> 0 through natural 2-bit overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 2'd1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
    end
  end

  // Occupancy: up on push only, down on pop only, steady on both or none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 3'd0;
    end else begin
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef QUAD_FIFO4_ERR_EN
  logic r_err;

  // Sticky misuse flag: a push dropped because the FIFO is full, or a pop
  // ignored because it is empty (even if a push is accepted alongside it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((wr_en && w_full && !rd_en) || (rd_en && w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ent0   = r_ent[0];
  assign ent1   = r_ent[1];
  assign ent2   = r_ent[2];
  assign ent3   = r_ent[3];
  assign rd_ptr = r_rdPtr;
  assign count  = r_count;
  assign empty  = w_empty;
  assign full   = w_full;

endmodule

// File: doc/quad_fifo4.md
# quad_fifo4

Four-entry, 4-bit circular FIFO that sits directly upstream of the quad 4:1 multiplexer. It holds the storage and pointer control: its four entry registers drive the mux data inputs InA..InD, and its read pointer drives the mux select S. The mux output is therefore always the head-of-queue word. All state is registered; the head data path through the mux is combinational.

## Interface
Parameters:
- none; depth is fixed at 4 and width at 4 bits, matching the quad 4:1 mux.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request.
- wr_data  input  4  word to push.
- rd_en  input  1  pop request; head word is consumed at the clock edge.
- ent0, ent1, ent2, ent3  output  4 each  storage entries; connect to mux InA, InB, InC, InD.
- rd_ptr  output  2  head index; connect to mux S.
- count  output  3  occupancy, 0..4.
- empty  output  1  count == 0.
- full  output  1  count == 4.
- err  output  1  sticky misuse flag; present only with the configuration macro, otherwise driven 0.

## Operation
- Storage: four 4-bit registers. The write pointer wr_ptr (2-bit, internal) and rd_ptr both wrap 3 -> 0 naturally.
- Push accepted (push_ok) when wr_en && (!full || rd_en). On push_ok, ent[wr_ptr] <= wr_data and wr_ptr <= wr_ptr + 1.
- Pop accepted (pop_ok) when rd_en && !empty. On pop_ok, rd_ptr <= rd_ptr + 1. Popped entry contents are not cleared.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Simultaneous push and pop:
  - when full, both are accepted and count stays 4;
  - when empty, only the push is accepted, the pop is ignored, and count becomes 1;
  - otherwise both are accepted and count is unchanged.
- Push while full without rd_en: the push is dropped and storage and pointers are unchanged.
- Pop while empty: ignored and pointers are unchanged.
- empty and full are decoded from registered count. There is no pointer-compare ambiguity.
- Head word = ent[rd_ptr] via the external mux. It is valid only when !empty.

## Timing
- Reset (asynchronous, immediate): ent0..ent3 = 0, rd_ptr = 0, wr_ptr = 0, count = 0, empty = 1, full = 0, err = 0.
- Write latency:
  - a word pushed at edge N appears on ent[wr_ptr] after edge N;
  - if the FIFO was empty, that word is the mux output after edge N (1 cycle).
- Pop: rd_ptr advances at the edge, so the next word is on the mux output in the following cycle.
- count, empty and full change only at clock edges. They never glitch combinationally on wr_en or rd_en.
- Reset asserted mid-operation discards all contents regardless of wr_en or rd_en. The first edge after deassertion behaves as from the empty state.

## Configuration
- Macro QUAD_FIFO4_ERR_EN.
- Defined:
  - err is set on any dropped push (wr_en && full && !rd_en) or ignored pop (rd_en && empty && !wr_en);
  - an ignored pop alongside an accepted push while empty also sets err;
  - err stays 1 until rst.
- Undefined: err is tied to 0, no error register is synthesized, and all other behaviour is identical.

## Test plan
- Reset, then no requests: ent0..3 = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, err = 0.
- Fill then drain:
  - push 4'h1, 4'h2, 4'h3, 4'h4 on 4 cycles -> count = 4, full = 1, ent0..3 = 1, 2, 3, 4;
  - then pop 4 cycles -> mux output sequence 1, 2, 3, 4, rd_ptr 0 -> 1 -> 2 -> 3 -> 0, empty = 1.
- Wrap-around:
  - push A, B, C, pop 2, push D, E, F -> count = 4;
  - ent0 = E, ent1 = F, ent2 = C, ent3 = D;
  - pops yield C, D, E, F.
- Full with push and pop together, push 4'h9 -> count stays 4, head advances, 4'h9 written into the slot just vacated.
- Empty with push and pop together, push 4'h7 -> count = 1, rd_ptr unchanged, mux output = 7; err = 1 only with QUAD_FIFO4_ERR_EN.
- Misuse and reset:
  - push while full without rd_en -> storage unchanged;
  - pop while empty -> rd_ptr unchanged;
  - err = 1 (macro) or 0 (no macro);
  - rst pulsed between clock edges with count = 3 -> all outputs return to reset values immediately.
